// File: rtl/uart_tx16.sv
// rtl/uart_tx16.sv - 16-bit word UART transmitter, high byte first; optional even parity via UART_PARITY_EN
module uart_tx16 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_tx,
    input  logic [15:0] tx_value,
    output logic        uart_ready,
    output logic        tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic           byte_sel;
    logic [15:0]    shift_reg;
    logic [7:0]     data_byte;
    logic           baud_done;

    // The byte on the wire is always the top byte; the low byte shifts up between bytes.
    assign data_byte  = shift_reg[15:8];
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign uart_ready = (state == IDLE) && !start_tx;

    // Frame sequencer: tx is registered and changes on the edge that enters each bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_sel  <= 1'b0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                    if (start_tx) begin
                        shift_reg <= tx_value;
                        byte_sel  <= 1'b0;
                        state     <= START;
                        tx        <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        tx       <= data_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            state   <= PARITY;
                            tx      <= ^data_byte;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= data_byte[3'(bit_cnt + 3'd1)];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!byte_sel) begin
                            // Second byte follows immediately, no idle gap.
                            byte_sel  <= 1'b1;
                            shift_reg <= {shift_reg[7:0], 8'h00};
                            state     <= START;
                            tx        <= 1'b0;
                        end else begin
                            byte_sel <= 1'b0;
                            state    <= IDLE;
                            tx       <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx16.md
UART_TX16 -- requirements
Module: uart_tx16

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud): clock cycles per serial bit; legal range is 2 or greater.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start_tx, input, 1 bit: request to transmit tx_value.
REQ-005 SHALL have port tx_value, input, 16 bits: signed num word to send.
REQ-006 SHALL have port uart_ready, output, 1 bit: high when a new word can be accepted.
REQ-007 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-008 SHALL use states IDLE, START, DATA, PARITY (macro only), STOP.
- Each state except IDLE holds for exactly CLKS_PER_BIT cycles per bit.
REQ-009 SHALL drive uart_ready = (state==IDLE) && !start_tx, combinationally.
- Upstream sees ready low in the same cycle it raises start_tx.
REQ-010 SHALL, in IDLE with start_tx=1 at a clock edge, latch tx_value into a 16-bit shift register and enter START for byte 0.
REQ-011 SHALL ignore start_tx outside IDLE; the latched word is not altered mid-frame.
REQ-012 SHALL send tx_value[15:8] first (byte 0), then tx_value[7:0] (byte 1).
REQ-013 SHALL frame each byte as follows.
- Start bit 0.
- 8 data bits, LSB first.
- Parity bit (macro only).
- Stop bit 1.
REQ-014 SHALL, at the end of byte 0 STOP, go directly to START of byte 1 with no idle gap.
REQ-015 SHALL, at the end of byte 1 STOP, return to IDLE.
REQ-016 SHALL register tx (no combinational path to tx); tx changes on the edge that enters each bit.
REQ-017 SHALL have these timing properties.
- Latency from the accepting edge to the start bit on tx: 1 cycle.
- Total busy time: 2*F*CLKS_PER_BIT cycles, where F=10, or F=11 with the macro.
REQ-018 SHALL use a bit counter of 0..7 and a baud counter of 0..CLKS_PER_BIT-1; both clear on every state change.
REQ-019 SHALL, when start_tx is held high continuously, accept a new word on the first IDLE cycle after the previous word completes.
- Back-to-back words are separated by exactly 1 idle cycle (tx=1).

Reset
REQ-020 SHALL, on reset=1 at a clock edge, set the following regardless of state, including mid-frame.
- state=IDLE, tx=1, counters=0, shift register=0.
REQ-021 SHALL, when reset is deasserted, evaluate uart_ready as 1 in the next cycle unless start_tx is high.
REQ-022 SHALL discard any partially sent word on reset; no resumption.

Configuration
REQ-023 SHALL, when macro UART_PARITY_EN is defined, insert a PARITY state after DATA for each byte.
- Parity bit: even parity, equal to the XOR of the 8 data bits.
- Frame: 11 bits per byte.
REQ-024 SHALL, when UART_PARITY_EN is undefined, omit the PARITY state and its logic entirely; frame: 10 bits per byte.

Verification
REQ-025 SHALL cover the basic frame.
- Stimulus: CLKS_PER_BIT=4, no macro, 1-cycle start_tx with tx_value=16'hA53C.
- Response: tx carries 0,10100101b LSB-first,1, then 0,00111100b LSB-first,1.
- Response: each bit is 4 cycles; uart_ready is low for 80 cycles from the start_tx cycle.
REQ-026 SHALL cover the ready handshake.
- Stimulus: start_tx asserted while idle.
- Response: uart_ready=0 in that same cycle.
- Response: uart_ready returns to 1 on the cycle after byte 1's stop bit ends.
REQ-027 SHALL cover start_tx while busy.
- Stimulus: pulse start_tx with 16'h1234 during byte 0 data of 16'hFFFF.
- Response: only 16'hFFFF is transmitted; 16'h1234 is ignored.
REQ-028 SHALL cover reset mid-frame.
- Stimulus: assert reset during byte 1 bit 3.
- Response: tx=1 and state IDLE after that edge.
- Response: uart_ready=1 the cycle after deassertion; no further bits are sent.
REQ-029 SHALL cover parity.
- Stimulus: UART_PARITY_EN defined, tx_value=16'h0700.
- Response: byte 0 parity bit=1, byte 1 parity bit=0; 11 bits per byte; busy for 88 cycles.
REQ-030 SHALL cover back-to-back words.
- Stimulus: start_tx held high with tx_value 16'h0001, then 16'h8000.
- Response: exactly 1 idle cycle with tx=1 between the words; byte order holds for both words.
